// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data cache memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_D_ACCESS = 3'd1;
  localparam logic [2:0] ST_I_ACCESS = 3'd2;
  localparam logic [2:0] ST_D_DONE   = 3'd3;
  localparam logic [2:0] ST_I_DONE   = 3'd4;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_D    = 2'b01;
  localparam logic [1:0] OWNER_I    = 2'b10;

endpackage

// File: rtl/arb_rr_picker.sv
// Two-way round-robin selector; on a tie the requester that did not go last wins.
module arb_rr_picker
  import mem_arb_pkg::*;
(
  input  logic       d_req,
  input  logic       i_req,
  input  logic [1:0] last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = OWNER_NONE;
    if (d_req && i_req)
      grant = (last_owner == OWNER_D) ? OWNER_I : OWNER_D;
    else if (d_req)
      grant = OWNER_D;
    else if (i_req)
      grant = OWNER_I;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache with a
// registered round-robin grant FSM; each cache sees a private busywait.
//
// state     | meaning
// IDLE      | no owner, arbitrate pending requests
// D_ACCESS  | data-cache command on the memory port
// I_ACCESS  | instruction-cache command on the memory port
// D_DONE    | one-cycle handoff, D_BUSYWAIT released
// I_DONE    | one-cycle handoff, I_BUSYWAIT released
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [DATA_W-1:0] D_WRITEDATA,
  output logic [DATA_W-1:0] D_READDATA,
  output logic              D_BUSYWAIT,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [DATA_W-1:0] I_READDATA,
  output logic              I_BUSYWAIT,
  output logic              M_READ,
  output logic              M_WRITE,
  output logic [ADDR_W-1:0] M_ADDRESS,
  output logic [DATA_W-1:0] M_WRITEDATA,
  input  logic [DATA_W-1:0] M_READDATA,
  input  logic              M_BUSYWAIT,
  output logic [1:0]        OWNER
);

  logic [2:0] state;
  logic [1:0] last_owner;
  logic       seen_busy;
  logic       d_req;
  logic       i_req;
  logic [1:0] grant;

  assign d_req = D_READ | D_WRITE;
  assign i_req = I_READ;

  assign D_BUSYWAIT = d_req & (state != ST_D_DONE);
  assign I_BUSYWAIT = i_req & (state != ST_I_DONE);

  arb_rr_picker u_picker (
    .d_req      (d_req),
    .i_req      (i_req),
    .last_owner (last_owner),
    .grant      (grant)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_IDLE;
      last_owner  <= OWNER_I;
      seen_busy   <= 1'b0;
      M_READ      <= 1'b0;
      M_WRITE     <= 1'b0;
      M_ADDRESS   <= '0;
      M_WRITEDATA <= '0;
      D_READDATA  <= '0;
      I_READDATA  <= '0;
      OWNER       <= OWNER_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          // Simultaneous read+write from the D-cache is treated as a write.
          if (grant == OWNER_D) begin
            M_READ      <= D_READ & ~D_WRITE;
            M_WRITE     <= D_WRITE;
            M_ADDRESS   <= D_ADDRESS;
            M_WRITEDATA <= D_WRITEDATA;
            OWNER       <= OWNER_D;
            seen_busy   <= 1'b0;
            state       <= ST_D_ACCESS;
          end else if (grant == OWNER_I) begin
            M_READ      <= 1'b1;
            M_WRITE     <= 1'b0;
            M_ADDRESS   <= I_ADDRESS;
            M_WRITEDATA <= '0;
            OWNER       <= OWNER_I;
            seen_busy   <= 1'b0;
            state       <= ST_I_ACCESS;
          end
        end
        ST_D_ACCESS, ST_I_ACCESS: begin
          // Memory must be seen busy before its idle level means completion.
          if (M_BUSYWAIT) begin
            seen_busy <= 1'b1;
          end else if (seen_busy) begin
            M_READ  <= 1'b0;
            M_WRITE <= 1'b0;
            if (state == ST_D_ACCESS) begin
              if (M_READ) D_READDATA <= M_READDATA;
              last_owner <= OWNER_D;
              state      <= ST_D_DONE;
            end else begin
              if (M_READ) I_READDATA <= M_READDATA;
              last_owner <= OWNER_I;
              state      <= ST_I_DONE;
            end
          end
        end
        ST_D_DONE, ST_I_DONE: begin
          OWNER <= OWNER_NONE;
          state <= ST_IDLE;
        end
        default: begin
          OWNER <= OWNER_NONE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays the memory.
module tb_mem_arbiter;

  logic        CLK;
  logic        RESET;
  logic        D_READ, D_WRITE;
  logic [5:0]  D_ADDRESS;
  logic [31:0] D_WRITEDATA, D_READDATA;
  logic        D_BUSYWAIT;
  logic        I_READ;
  logic [5:0]  I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        M_READ, M_WRITE;
  logic [5:0]  M_ADDRESS;
  logic [31:0] M_WRITEDATA, M_READDATA;
  logic        M_BUSYWAIT;
  logic [1:0]  OWNER;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS),
    .D_WRITEDATA(D_WRITEDATA), .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA),
    .I_BUSYWAIT(I_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS),
    .M_WRITEDATA(M_WRITEDATA), .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT),
    .OWNER(OWNER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory busy for busy_n edges, then returns rdata; ends in the DONE cycle.
  task automatic mem_txn(input int busy_n, input logic [31:0] rdata);
    M_BUSYWAIT = 1'b1;
    repeat (busy_n) tick();
    M_BUSYWAIT = 1'b0;
    M_READDATA = rdata;
    tick();
  endtask

  initial begin
    RESET = 1'b1;
    D_READ = 0; D_WRITE = 0; D_ADDRESS = '0; D_WRITEDATA = '0;
    I_READ = 0; I_ADDRESS = '0;
    M_READDATA = '0; M_BUSYWAIT = 0;

    // 1. reset then idle
    repeat (2) tick();
    RESET = 1'b0;
    tick();
    check("rst_m_read", M_READ, 0);
    check("rst_m_write", M_WRITE, 0);
    check("rst_m_addr", M_ADDRESS, 0);
    check("rst_m_wdata", M_WRITEDATA, 0);
    check("rst_d_rdata", D_READDATA, 0);
    check("rst_i_rdata", I_READDATA, 0);
    check("rst_owner", OWNER, 2'b00);
    check("rst_d_busy", D_BUSYWAIT, 0);
    check("rst_i_busy", I_BUSYWAIT, 0);

    // 2. D read
    D_READ = 1; D_ADDRESS = 6'h05;
    #1;
    check("dr_busy_same_cycle", D_BUSYWAIT, 1);
    check("dr_m_read_not_yet", M_READ, 0);
    tick();
    check("dr_m_read", M_READ, 1);
    check("dr_m_addr", M_ADDRESS, 6'h05);
    check("dr_owner", OWNER, 2'b01);
    tick();
    check("dr_no_early_done", D_BUSYWAIT, 1);
    check("dr_hold_m_read", M_READ, 1);
    mem_txn(5, 32'hDEADBEEF);
    check("dr_rdata", D_READDATA, 32'hDEADBEEF);
    check("dr_busy_released", D_BUSYWAIT, 0);
    check("dr_m_read_cleared", M_READ, 0);
    check("dr_done_owner", OWNER, 2'b01);
    tick();
    check("dr_busy_one_cycle", D_BUSYWAIT, 1);
    check("dr_idle_owner", OWNER, 2'b00);
    D_READ = 0;
    #1;

    // 3. D write
    D_WRITE = 1; D_ADDRESS = 6'h3F; D_WRITEDATA = 32'h12345678;
    tick();
    check("dw_m_write", M_WRITE, 1);
    check("dw_m_read", M_READ, 0);
    check("dw_m_addr", M_ADDRESS, 6'h3F);
    check("dw_m_wdata", M_WRITEDATA, 32'h12345678);
    D_ADDRESS = 6'h01; D_WRITEDATA = 32'h0;
    mem_txn(3, 32'hCAFEF00D);
    check("dw_addr_held", M_ADDRESS, 6'h3F);
    check("dw_rdata_unchanged", D_READDATA, 32'hDEADBEEF);
    check("dw_busy_released", D_BUSYWAIT, 0);
    check("dw_m_write_cleared", M_WRITE, 0);
    D_WRITE = 0;
    tick();

    // 4. simultaneous requests after reset
    RESET = 1;
    repeat (2) tick();
    RESET = 0;
    D_READ = 1; D_ADDRESS = 6'h0A;
    I_READ = 1; I_ADDRESS = 6'h0B;
    #1;
    check("tie_d_busy", D_BUSYWAIT, 1);
    check("tie_i_busy", I_BUSYWAIT, 1);
    tick();
    check("tie_owner_d", OWNER, 2'b01);
    check("tie_addr_d", M_ADDRESS, 6'h0A);
    mem_txn(2, 32'h11111111);
    check("tie_d_rdata", D_READDATA, 32'h11111111);
    check("tie_i_busy_during_d", I_BUSYWAIT, 1);
    D_READ = 0;
    tick();
    check("tie_idle_owner", OWNER, 2'b00);
    check("tie_idle_i_busy", I_BUSYWAIT, 1);
    check("tie_idle_m_read", M_READ, 0);
    tick();
    check("tie_owner_i", OWNER, 2'b10);
    check("tie_addr_i", M_ADDRESS, 6'h0B);
    check("tie_i_m_read", M_READ, 1);
    mem_txn(2, 32'h22222222);
    check("tie_i_rdata", I_READDATA, 32'h22222222);
    check("tie_i_released", I_BUSYWAIT, 0);
    I_READ = 0;
    tick();
    // make D the last owner, then tie again
    D_READ = 1; D_ADDRESS = 6'h0C;
    tick();
    mem_txn(1, 32'h44444444);
    D_READ = 0;
    tick();
    D_READ = 1; D_ADDRESS = 6'h0D;
    I_READ = 1; I_ADDRESS = 6'h0E;
    tick();
    check("tie2_owner_i", OWNER, 2'b10);
    check("tie2_addr_i", M_ADDRESS, 6'h0E);
    check("tie2_d_busy", D_BUSYWAIT, 1);
    mem_txn(1, 32'h55555555);
    check("tie2_i_rdata", I_READDATA, 32'h55555555);
    I_READ = 0;
    tick();
    tick();
    check("tie2_then_d", OWNER, 2'b01);
    mem_txn(1, 32'h66666666);
    D_READ = 0;
    tick();

    // 5. withdrawal during I access
    I_READ = 1; I_ADDRESS = 6'h21;
    tick();
    check("wd_owner", OWNER, 2'b10);
    M_BUSYWAIT = 1;
    repeat (2) tick();
    I_READ = 0;
    #1;
    check("wd_i_busy_no_req", I_BUSYWAIT, 0);
    check("wd_m_read_held", M_READ, 1);
    repeat (2) tick();
    check("wd_m_read_still", M_READ, 1);
    check("wd_owner_still", OWNER, 2'b10);
    M_BUSYWAIT = 0; M_READDATA = 32'h33333333;
    tick();
    check("wd_i_rdata", I_READDATA, 32'h33333333);
    check("wd_done_owner", OWNER, 2'b10);
    D_READ = 1; D_ADDRESS = 6'h2A;
    tick();
    check("wd_no_grant_in_done", OWNER, 2'b00);
    check("wd_idle_m_read", M_READ, 0);
    tick();
    check("wd_d_granted", OWNER, 2'b01);
    check("wd_d_addr", M_ADDRESS, 6'h2A);

    // 6. reset mid-access
    M_BUSYWAIT = 1;
    repeat (2) tick();
    RESET = 1; M_BUSYWAIT = 0;
    tick();
    check("mr_m_read", M_READ, 0);
    check("mr_m_write", M_WRITE, 0);
    check("mr_owner", OWNER, 2'b00);
    check("mr_i_rdata", I_READDATA, 0);
    check("mr_d_busy_idle", D_BUSYWAIT, 1);
    RESET = 0; D_READ = 0;
    tick();
    check("mr_stays_idle", OWNER, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
